// File: rtl/cva5_types.sv
// Shared fetch-path types: per-request metadata and the fetch buffer entry layout.
package cva5_types;

    localparam int FETCH_ID_W = 3;

    typedef struct packed {
        logic       ok;
        logic [1:0] error_code;
    } fetch_metadata_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [FETCH_ID_W-1:0] id;
        logic [31:0]           instruction;
        fetch_metadata_t       metadata;
        logic                  filled;
    } fetch_buffer_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order buffer between fetch and decode: slots are allocated on issue,
// filled in order on completion, and drained by decode through valid/ready.
module fetch_buffer
    import cva5_types::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = FETCH_ID_W  // entry id field is sized by the package
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                issue,
    input  logic [31:0]                         issue_pc,
    input  logic [ID_W-1:0]                     issue_id,
    output logic                                space_available,
    input  logic                                complete,
    input  logic [31:0]                         complete_instruction,
    input  logic [$bits(fetch_metadata_t)-1:0]  complete_metadata,
    output logic                                decode_valid,
    input  logic                                decode_ready,
    output logic [31:0]                         decode_pc,
    output logic [ID_W-1:0]                     decode_id,
    output logic [31:0]                         decode_instruction,
    output logic [$bits(fetch_metadata_t)-1:0]  decode_metadata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_buffer_entry_t entries [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] fill;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] alloc_count;
    logic [CNT_W-1:0] pending_count;

    logic full;
    logic pop;
    logic issue_ok;
    logic complete_ok;

    assign full            = (alloc_count == CNT_W'(DEPTH));
    assign space_available = ~full;
    assign decode_valid    = (pending_count != '0);
    assign pop             = decode_valid & decode_ready;

    // A pop frees the head slot in the same cycle, so an issue at full is
    // still accepted when it coincides with a pop.
    assign issue_ok    = issue & (~full | pop);
    assign complete_ok = complete & (alloc_count != pending_count);

    assign decode_pc          = entries[head].pc;
    assign decode_id          = entries[head].id;
    assign decode_instruction = entries[head].instruction;
    assign decode_metadata    = entries[head].metadata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            fill          <= '0;
            tail          <= '0;
            alloc_count   <= '0;
            pending_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head          <= '0;
            fill          <= '0;
            tail          <= '0;
            alloc_count   <= '0;
            pending_count <= '0;
        end else begin
            if (issue_ok) begin
                entries[tail].pc     <= issue_pc;
                entries[tail].id     <= issue_id;
                entries[tail].filled <= 1'b0;
                tail                 <= tail + PTR_W'(1);
            end
            if (complete_ok) begin
                entries[fill].instruction <= complete_instruction;
                entries[fill].metadata    <= fetch_metadata_t'(complete_metadata);
                entries[fill].filled      <= 1'b1;
                fill                      <= fill + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            alloc_count   <= alloc_count + CNT_W'(issue_ok) - CNT_W'(pop);
            pending_count <= pending_count + CNT_W'(complete_ok) - CNT_W'(pop);
        end
    end

    a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
        (issue && !flush) |-> (!full || pop));

    a_no_complete_without_slot: assert property (@(posedge clk) disable iff (rst)
        (complete && !flush) |-> (alloc_count != pending_count));

    a_count_bounds: assert property (@(posedge clk) disable iff (rst)
        (pending_count <= alloc_count) && (alloc_count <= CNT_W'(DEPTH)));

    a_head_filled: assert property (@(posedge clk) disable iff (rst)
        decode_valid |-> entries[head].filled);

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue-based reference model checked every cycle.
module tb_fetch_buffer;
    import cva5_types::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        issue = 1'b0;
    logic [31:0] issue_pc = '0;
    logic [2:0]  issue_id = '0;
    logic        space_available;
    logic        complete = 1'b0;
    logic [31:0] complete_instruction = '0;
    logic [2:0]  complete_metadata = '0;
    logic        decode_valid;
    logic        decode_ready = 1'b0;
    logic [31:0] decode_pc;
    logic [2:0]  decode_id;
    logic [31:0] decode_instruction;
    logic [2:0]  decode_metadata;

    int total = 0;
    int bad = 0;

    fetch_buffer #(.DEPTH(DEPTH), .ID_W(3)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .issue                (issue),
        .issue_pc             (issue_pc),
        .issue_id             (issue_id),
        .space_available      (space_available),
        .complete             (complete),
        .complete_instruction (complete_instruction),
        .complete_metadata    (complete_metadata),
        .decode_valid         (decode_valid),
        .decode_ready         (decode_ready),
        .decode_pc            (decode_pc),
        .decode_id            (decode_id),
        .decode_instruction   (decode_instruction),
        .decode_metadata      (decode_metadata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: queue of in-flight requests, oldest first.
    typedef struct {
        logic [31:0] pc;
        logic [2:0]  id;
        logic [31:0] ins;
        logic [2:0]  meta;
        bit          filled;
    } ent_t;

    ent_t q[$];
    bit   m_pop;
    bit   m_full;
    bit   m_done;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            m_pop  = decode_ready && q.size() > 0 && q[0].filled;
            m_full = (q.size() == DEPTH);
            m_done = 1'b0;
            if (complete) begin
                foreach (q[i]) begin
                    if (!m_done && !q[i].filled) begin
                        q[i].ins    = complete_instruction;
                        q[i].meta   = complete_metadata;
                        q[i].filled = 1'b1;
                        m_done      = 1'b1;
                    end
                end
            end
            if (m_pop) void'(q.pop_front());
            if (issue && (!m_full || m_pop))
                q.push_back('{pc: issue_pc, id: issue_id, ins: 32'h0, meta: 3'h0, filled: 1'b0});
        end
    end

    int  c_filled;
    bit  c_valid;

    always @(negedge clk) begin
        c_filled = 0;
        foreach (q[i]) if (q[i].filled) c_filled++;
        c_valid = (q.size() > 0) && q[0].filled;
        chk("valid", 64'(decode_valid), 64'(c_valid));
        chk("space", 64'(space_available), 64'(q.size() < DEPTH));
        chk("alloc_count", 64'(dut.alloc_count), 64'(q.size()));
        chk("pending_count", 64'(dut.pending_count), 64'(c_filled));
        if (c_valid) begin
            chk("pc", 64'(decode_pc), 64'(q[0].pc));
            chk("id", 64'(decode_id), 64'(q[0].id));
            chk("instr", 64'(decode_instruction), 64'(q[0].ins));
            chk("meta", 64'(decode_metadata), 64'(q[0].meta));
        end
    end

    function automatic bit has_unfilled();
        foreach (q[i]) if (!q[i].filled) return 1'b1;
        return 1'b0;
    endfunction

    // Apply inputs for one cycle starting at a falling edge; returns at the next falling edge.
    task automatic drive(input logic iss, input logic [31:0] pc, input logic [2:0] id,
                         input logic cmp, input logic [31:0] ins, input logic [2:0] meta,
                         input logic rdy, input logic fl);
        issue = iss; issue_pc = pc; issue_id = id;
        complete = cmp; complete_instruction = ins; complete_metadata = meta;
        decode_ready = rdy; flush = fl;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue = 1'b0; complete = 1'b0; decode_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0) break;
            drive(1'b0, 32'h0, 3'h0, has_unfilled(), 32'hC000_0000 + 32'(k), 3'b100, 1'b1, 1'b0);
        end
        chk("drain_empty", 64'(dut.alloc_count), 64'd0);
    endtask

    logic [31:0] got_pc[$];
    logic [2:0]  got_id[$];

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(decode_valid), 64'd0);
        chk("rst_space", 64'(space_available), 64'd1);
        chk("rst_pc", 64'(decode_pc), 64'd0);
        chk("rst_id", 64'(decode_id), 64'd0);
        chk("rst_instr", 64'(decode_instruction), 64'd0);
        chk("rst_meta", 64'(decode_metadata), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single issue, complete, pop.
        drive(1'b1, 32'h8000_0000, 3'd1, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        chk("t1_not_valid", 64'(decode_valid), 64'd0);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h0000_0013, 3'b100, 1'b0, 1'b0);
        chk("t1_valid", 64'(decode_valid), 64'd1);
        chk("t1_pc", 64'(decode_pc), 64'h8000_0000);
        chk("t1_id", 64'(decode_id), 64'd1);
        chk("t1_instr", 64'(decode_instruction), 64'h13);
        chk("t1_meta", 64'(decode_metadata), 64'b100);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);
        chk("t1_popped", 64'(decode_valid), 64'd0);

        // Fill to capacity, issue+pop at full, then pop alone.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h200 + 32'(4 * i), 3'(i), 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        chk("t2_full_space", 64'(space_available), 64'd0);
        chk("t2_full_alloc", 64'(dut.alloc_count), 64'd4);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'hA0, 3'b100, 1'b0, 1'b0);
        chk("t2_head_valid", 64'(decode_valid), 64'd1);
        drive(1'b1, 32'h210, 3'd4, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);
        chk("t2_issue_pop_alloc", 64'(dut.alloc_count), 64'd4);
        chk("t2_issue_pop_space", 64'(space_available), 64'd0);
        chk("t2_next_pc", 64'(decode_pc), 64'h204);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'hA1, 3'b100, 1'b0, 1'b0);
        chk("t2_still_full", 64'(space_available), 64'd0);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);
        chk("t2_space_back", 64'(space_available), 64'd1);
        chk("t2_alloc3", 64'(dut.alloc_count), 64'd3);
        drain();

        // Back-pressure holds head stable, then in-order drain.
        drive(1'b1, 32'h300, 3'd1, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 3'd2, 1'b1, 32'h11, 3'b100, 1'b0, 1'b0);
        drive(1'b1, 32'h308, 3'd3, 1'b1, 32'h22, 3'b101, 1'b0, 1'b0);
        chk("t3_valid", 64'(decode_valid), 64'd1);
        chk("t3_pc_a", 64'(decode_pc), 64'h300);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        chk("t3_hold_pc", 64'(decode_pc), 64'h300);
        chk("t3_hold_instr", 64'(decode_instruction), 64'h11);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);
        chk("t3_pc_b", 64'(decode_pc), 64'h304);
        chk("t3_meta_b", 64'(decode_metadata), 64'b101);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);
        chk("t3_c_not_valid", 64'(decode_valid), 64'd0);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h33, 3'b100, 1'b1, 1'b0);
        chk("t3_c_valid", 64'(decode_valid), 64'd1);
        chk("t3_pc_c", 64'(decode_pc), 64'h308);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);
        chk("t3_empty", 64'(decode_valid), 64'd0);

        // Flush with three allocated, two filled, and concurrent issue/complete.
        drive(1'b1, 32'h400, 3'd1, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h404, 3'd2, 1'b1, 32'h44, 3'b100, 1'b0, 1'b0);
        drive(1'b1, 32'h408, 3'd3, 1'b1, 32'h45, 3'b100, 1'b0, 1'b0);
        drive(1'b1, 32'h500, 3'd5, 1'b1, 32'h55, 3'b100, 1'b0, 1'b1);
        chk("t4_valid", 64'(decode_valid), 64'd0);
        chk("t4_space", 64'(space_available), 64'd1);
        chk("t4_alloc", 64'(dut.alloc_count), 64'd0);
        chk("t4_pending", 64'(dut.pending_count), 64'd0);
        drive(1'b1, 32'h100, 3'd6, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        chk("t4_head0", 64'(dut.head), 64'd0);
        chk("t4_tail1", 64'(dut.tail), 64'd1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h66, 3'b100, 1'b0, 1'b0);
        chk("t4_first_pc", 64'(decode_pc), 64'h100);
        chk("t4_first_id", 64'(decode_id), 64'd6);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);

        // Pipelined stream across pointer wrap.
        for (int k = 0; k < 12; k++) begin
            if (decode_valid) begin
                got_pc.push_back(decode_pc);
                got_id.push_back(decode_id);
            end
            drive(k < 10, 32'(4 * k), 3'(k), (k >= 1 && k <= 10), 32'h1000 + 32'(k), 3'b100, 1'b1, 1'b0);
        end
        chk("t5_count", 64'(got_pc.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_pc.size()) begin
                chk("t5_order_pc", 64'(got_pc[i]), 64'(4 * i));
                chk("t5_order_id", 64'(got_id[i]), 64'(i % 8));
            end
        end
        drain();

        // Asynchronous reset between clock edges.
        drive(1'b1, 32'h600, 3'd1, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h604, 3'd2, 1'b1, 32'h77, 3'b011, 1'b0, 1'b0);
        idle_inputs();
        chk("t6_pre_valid", 64'(decode_valid), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 64'(decode_valid), 64'd0);
        chk("t6_space", 64'(space_available), 64'd1);
        chk("t6_pc", 64'(decode_pc), 64'd0);
        chk("t6_id", 64'(decode_id), 64'd0);
        chk("t6_instr", 64'(decode_instruction), 64'd0);
        chk("t6_meta", 64'(decode_metadata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h700, 3'd3, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0);
        chk("t6_alloc", 64'(dut.alloc_count), 64'd1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h88, 3'b100, 1'b0, 1'b0);
        chk("t6_resume_pc", 64'(decode_pc), 64'h700);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'h0, 1'b1, 1'b0);
        chk("t6_resume_empty", 64'(decode_valid), 64'd0);

        idle_inputs();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
